// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes,
// ALU operation codes and datapath mux selects.
package riscv_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_ADR,
    S_MEM_READ,
    S_MEM_WB,
    S_MEM_WRITE,
    S_EXEC_R,
    S_EXEC_I,
    S_ALU_WB,
    S_BRANCH,
    S_JAL,
    S_LUI,
    S_TRAP
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_ctrl_e;

  // What the FSM asks of the ALU decoder: a fixed op, or decode from funct fields.
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_e;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_RS1   = 2'b10;
  localparam logic [1:0] SRC_A_ZERO  = 2'b11;

  localparam logic [1:0] SRC_B_RS2  = 2'b00;
  localparam logic [1:0] SRC_B_IMM  = 2'b01;
  localparam logic [1:0] SRC_B_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  // funct3 010/011 have no branch meaning in RV32I.
  function automatic logic branch_legal(input logic [2:0] funct3);
    return funct3[2:1] != 2'b01;
  endfunction

endpackage

// File: rtl/alu_decoder_ext.sv
// ALU operation decoder: maps the FSM's alu_op request plus the instruction's
// funct fields onto an ALU control code.
module alu_decoder_ext
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4
) (
  input  logic [6:0]            op_code,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  alu_op_e               alu_op,
  output logic [ALU_CTRL_W-1:0] alu_control
);

  alu_ctrl_e op;

  // Only op_code[5] (R vs I form) and funct7[5] (SUB/SRA select) matter here.
  logic unused_fields;
  assign unused_fields = ^{op_code[6], op_code[4:0], funct7[6], funct7[4:0]};

  always_comb begin
    op = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB: op = ALU_SUB;
      ALU_OP_FUNCT: begin
        case (funct3)
          3'b000:  op = (op_code[5] & funct7[5]) ? ALU_SUB : ALU_ADD;
          3'b001:  op = ALU_SLL;
          3'b010:  op = ALU_SLT;
          3'b011:  op = ALU_SLTU;
          3'b100:  op = ALU_XOR;
          3'b101:  op = funct7[5] ? ALU_SRA : ALU_SRL;
          3'b110:  op = ALU_OR;
          default: op = ALU_AND;
        endcase
      end
      default: op = ALU_ADD;
    endcase
  end

  assign alu_control = ALU_CTRL_W'(op);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: sequences fetch/decode/execute over a shared
// memory and ALU, with memory wait handshake, illegal trap and instret counter.
//
// state       | meaning
// S_FETCH     | read instruction at PC, PC+4 on completion
// S_DECODE    | branch/jump target into ALUOut, dispatch on opcode
// S_MEM_ADR   | rs1+imm effective address
// S_MEM_READ  | load request, wait for mem_ready
// S_MEM_WB    | load data to register file
// S_MEM_WRITE | store request, wait for mem_ready
// S_EXEC_R    | rs1 op rs2
// S_EXEC_I    | rs1 op imm
// S_ALU_WB    | ALUOut to register file
// S_BRANCH    | compare rs1/rs2, load PC from ALUOut if taken
// S_JAL       | load PC with target, compute return address
// S_LUI       | zero + U-immediate
// S_TRAP      | unsupported instruction, parked until reset
module multicycle_control
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [6:0]            op_code,
  input  logic [2:0]            funct3,
  input  logic [6:0]            funct7,
  input  logic                  zero,
  input  logic                  lt,
  input  logic                  ltu,
  input  logic                  mem_ready,
  output logic                  mem_req,
  output logic                  mem_w,
  output logic                  adr_src,
  output logic                  ir_w,
  output logic                  pc_w,
  output logic                  reg_w,
  output logic [1:0]            result_src,
  output logic [1:0]            alu_src_a,
  output logic [1:0]            alu_src_b,
  output logic [2:0]            imm_src,
  output logic [ALU_CTRL_W-1:0] alu_control,
  output logic                  illegal,
  output logic [CNT_W-1:0]      instret
);

  state_t  state;
  alu_op_e alu_op;
  logic    taken;
  logic    f3_ok;
  logic    retire;

  alu_decoder_ext #(.ALU_CTRL_W(ALU_CTRL_W)) u_alu_dec (
    .op_code    (op_code),
    .funct3     (funct3),
    .funct7     (funct7),
    .alu_op     (alu_op),
    .alu_control(alu_control)
  );

  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = lt;
      3'b101:  taken = ~lt;
      3'b110:  taken = ltu;
      3'b111:  taken = ~ltu;
      default: taken = 1'b0;
    endcase
  end

  assign f3_ok  = branch_legal(funct3);
  assign retire = (state == S_MEM_WB) || (state == S_ALU_WB) ||
                  (state == S_MEM_WRITE && mem_ready) ||
                  (state == S_BRANCH && f3_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      instret <= '0;
    end else begin
      if (retire) instret <= instret + CNT_W'(1);
      case (state)
        S_FETCH:     if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          case (op_code)
            OP_LOAD, OP_STORE: state <= S_MEM_ADR;
            OP_R:              state <= S_EXEC_R;
            OP_I:              state <= S_EXEC_I;
            OP_BRANCH:         state <= S_BRANCH;
            OP_JAL:            state <= S_JAL;
            OP_LUI:            state <= S_LUI;
            default:           state <= S_TRAP;
          endcase
        end
        S_MEM_ADR:   state <= op_code[5] ? S_MEM_WRITE : S_MEM_READ;
        S_MEM_READ:  if (mem_ready) state <= S_MEM_WB;
        S_MEM_WB:    state <= S_FETCH;
        S_MEM_WRITE: if (mem_ready) state <= S_FETCH;
        S_EXEC_R, S_EXEC_I, S_LUI, S_JAL: state <= S_ALU_WB;
        S_ALU_WB:    state <= S_FETCH;
        S_BRANCH:    state <= f3_ok ? S_FETCH : S_TRAP;
        S_TRAP:      state <= S_TRAP;
        default:     state <= S_FETCH;
      endcase
    end
  end

  // Decoding is gated by rst_n so that asserting reset kills every request at once.
  always_comb begin
    mem_req    = 1'b0;
    mem_w      = 1'b0;
    adr_src    = 1'b0;
    ir_w       = 1'b0;
    pc_w       = 1'b0;
    reg_w      = 1'b0;
    result_src = RES_ALUOUT;
    alu_src_a  = SRC_A_PC;
    alu_src_b  = SRC_B_RS2;
    imm_src    = IMM_I;
    alu_op     = ALU_OP_ADD;
    illegal    = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: begin
          mem_req    = 1'b1;
          ir_w       = mem_ready;
          pc_w       = mem_ready;
          alu_src_b  = SRC_B_FOUR;
          result_src = RES_ALU;
        end
        S_DECODE: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_IMM;
          case (op_code)
            OP_STORE:  imm_src = IMM_S;
            OP_BRANCH: imm_src = IMM_B;
            OP_JAL:    imm_src = IMM_J;
            OP_LUI:    imm_src = IMM_U;
            default:   imm_src = IMM_I;
          endcase
        end
        S_MEM_ADR: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          imm_src   = op_code[5] ? IMM_S : IMM_I;
        end
        S_MEM_READ: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
        end
        S_MEM_WB: begin
          result_src = RES_RDATA;
          reg_w      = 1'b1;
        end
        S_MEM_WRITE: begin
          mem_req = 1'b1;
          mem_w   = 1'b1;
          adr_src = 1'b1;
        end
        S_EXEC_R: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_OP_FUNCT;
        end
        S_EXEC_I: begin
          alu_src_a = SRC_A_RS1;
          alu_src_b = SRC_B_IMM;
          alu_op    = ALU_OP_FUNCT;
        end
        S_ALU_WB: reg_w = 1'b1;
        S_BRANCH: begin
          alu_src_a = SRC_A_RS1;
          alu_op    = ALU_OP_SUB;
          pc_w      = taken & f3_ok;
        end
        S_JAL: begin
          alu_src_a = SRC_A_OLDPC;
          alu_src_b = SRC_B_FOUR;
          pc_w      = 1'b1;
        end
        S_LUI: begin
          alu_src_a = SRC_A_ZERO;
          alu_src_b = SRC_B_IMM;
          imm_src   = IMM_U;
        end
        S_TRAP:  illegal = 1'b1;
        default: illegal = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Cycle-level bench for multicycle_control: per-cycle expected controls and
// instret are queued with the stimulus and compared at the falling edge.
module tb_multicycle_control;

  typedef struct packed {
    logic       mem_req, mem_w, adr_src, ir_w, pc_w, reg_w;
    logic [1:0] rs, a, b;
    logic [2:0] imm;
    logic [3:0] alu;
    logic       ill;
  } ctl_t;

  typedef struct packed {
    logic       rst;
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       z, l, lu, rdy;
  } stim_t;

  typedef struct {
    ctl_t        c;
    logic [31:0] cnt;
    string       nm;
  } exp_t;

  localparam logic [6:0] T_LOAD = 7'b0000011, T_STORE = 7'b0100011, T_R = 7'b0110011;
  localparam logic [6:0] T_I = 7'b0010011, T_BR = 7'b1100011, T_JAL = 7'b1101111;
  localparam logic [6:0] T_LUI = 7'b0110111, T_SYS = 7'b1110011;

  logic clk = 1'b0;
  logic rst_n;
  logic [6:0] op_code, funct7;
  logic [2:0] funct3;
  logic zero, lt, ltu, mem_ready;
  logic mem_req, mem_w, adr_src, ir_w, pc_w, reg_w, illegal;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src;
  logic [3:0] alu_control;
  logic [31:0] instret;

  logic d4_mem_req, d4_mem_w, d4_adr_src, d4_ir_w, d4_pc_w, d4_reg_w, d4_illegal;
  logic [1:0] d4_result_src, d4_alu_src_a, d4_alu_src_b;
  logic [2:0] d4_imm_src;
  logic [3:0] d4_alu_control;
  logic [3:0] instret4;

  ctl_t obs;
  assign obs = {mem_req, mem_w, adr_src, ir_w, pc_w, reg_w, result_src, alu_src_a,
                alu_src_b, imm_src, alu_control, illegal};

  int checks = 0;
  int errors = 0;
  logic [31:0] model_cnt = 0;
  stim_t stim_q[$];
  exp_t  exp_q[$];

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(mem_req),
    .mem_w(mem_w), .adr_src(adr_src), .ir_w(ir_w), .pc_w(pc_w), .reg_w(reg_w),
    .result_src(result_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .imm_src(imm_src), .alu_control(alu_control), .illegal(illegal), .instret(instret)
  );

  multicycle_control #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .op_code(op_code), .funct3(funct3), .funct7(funct7),
    .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready), .mem_req(d4_mem_req),
    .mem_w(d4_mem_w), .adr_src(d4_adr_src), .ir_w(d4_ir_w), .pc_w(d4_pc_w),
    .reg_w(d4_reg_w), .result_src(d4_result_src), .alu_src_a(d4_alu_src_a),
    .alu_src_b(d4_alu_src_b), .imm_src(d4_imm_src), .alu_control(d4_alu_control),
    .illegal(d4_illegal), .instret(instret4)
  );

  // Expected control vectors, one per FSM state.
  function automatic ctl_t c_fetch(input logic rdy);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.ir_w = rdy; c.pc_w = rdy; c.rs = 2'b10; c.b = 2'b10;
    return c;
  endfunction
  function automatic ctl_t c_dec(input logic [2:0] imm);
    ctl_t c = '0;
    c.a = 2'b01; c.b = 2'b01; c.imm = imm;
    return c;
  endfunction
  function automatic ctl_t c_exec(input logic [3:0] alu, input logic is_r);
    ctl_t c = '0;
    c.a = 2'b10; c.b = is_r ? 2'b00 : 2'b01; c.alu = alu;
    return c;
  endfunction
  function automatic ctl_t c_wb(input logic [1:0] rs);
    ctl_t c = '0;
    c.reg_w = 1'b1; c.rs = rs;
    return c;
  endfunction
  function automatic ctl_t c_madr(input logic [2:0] imm);
    ctl_t c = '0;
    c.a = 2'b10; c.b = 2'b01; c.imm = imm;
    return c;
  endfunction
  function automatic ctl_t c_mem(input logic wr);
    ctl_t c = '0;
    c.mem_req = 1'b1; c.adr_src = 1'b1; c.mem_w = wr;
    return c;
  endfunction
  function automatic ctl_t c_br(input logic tk);
    ctl_t c = '0;
    c.a = 2'b10; c.alu = 4'd1; c.pc_w = tk;
    return c;
  endfunction
  function automatic ctl_t c_jal();
    ctl_t c = '0;
    c.a = 2'b01; c.b = 2'b10; c.pc_w = 1'b1;
    return c;
  endfunction
  function automatic ctl_t c_lui();
    ctl_t c = '0;
    c.a = 2'b11; c.b = 2'b01; c.imm = 3'b100;
    return c;
  endfunction
  function automatic ctl_t c_trap();
    ctl_t c = '0;
    c.ill = 1'b1;
    return c;
  endfunction

  function automatic stim_t st(input logic [6:0] op, input logic [2:0] f3,
                               input logic [6:0] f7, input logic rdy, input logic [2:0] flg);
    stim_t s;
    s.rst = 1'b1; s.op = op; s.f3 = f3; s.f7 = f7; s.rdy = rdy;
    {s.z, s.l, s.lu} = flg;
    return s;
  endfunction

  task automatic push(input stim_t s, input ctl_t c, input logic ret, input string nm);
    exp_t e;
    if (!s.rst) model_cnt = 0;
    e.c = s.rst ? c : '0;
    e.cnt = model_cnt;
    e.nm = nm;
    stim_q.push_back(s);
    exp_q.push_back(e);
    if (ret && s.rst) model_cnt = model_cnt + 1;
  endtask

  task automatic push_rst(input string nm);
    stim_t s = st(7'd0, 3'd0, 7'd0, 1'b1, 3'b000);
    s.rst = 1'b0;
    push(s, '0, 1'b0, nm);
  endtask

  task automatic push_alu(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                          input logic [3:0] alu, input string nm);
    push(st(op, f3, f7, 1'b1, 3'b000), c_fetch(1'b1), 1'b0, {nm, ".fetch"});
    push(st(op, f3, f7, 1'b1, 3'b000), c_dec(3'b000), 1'b0, {nm, ".decode"});
    push(st(op, f3, f7, 1'b1, 3'b000), c_exec(alu, op == T_R), 1'b0, {nm, ".exec"});
    push(st(op, f3, f7, 1'b0, 3'b000), c_wb(2'b00), 1'b1, {nm, ".wb"});
  endtask

  task automatic push_br(input logic [2:0] f3, input logic [2:0] flg, input logic tk,
                         input string nm);
    push(st(T_BR, f3, 7'd0, 1'b1, flg), c_fetch(1'b1), 1'b0, {nm, ".fetch"});
    push(st(T_BR, f3, 7'd0, 1'b0, flg), c_dec(3'b010), 1'b0, {nm, ".decode"});
    push(st(T_BR, f3, 7'd0, 1'b1, flg), c_br(tk), 1'b1, {nm, ".branch"});
  endtask

  task automatic drive(input stim_t s);
    rst_n = s.rst; op_code = s.op; funct3 = s.f3; funct7 = s.f7;
    zero = s.z; lt = s.l; ltu = s.lu; mem_ready = s.rdy;
  endtask

  task automatic test_reset();
    stim_t s; exp_t e;
    push_rst("reset0");
    push_rst("reset1");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s);
      @(negedge clk);
      checks++;
      if (obs !== e.c) begin errors++; $display("FAIL %s: controls got %h want %h", e.nm, obs, e.c); end
      checks++;
      if (instret !== e.cnt || instret4 !== e.cnt[3:0]) begin
        errors++; $display("FAIL %s: instret got %0d/%0d want %0d", e.nm, instret, instret4, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu_ops();
    stim_t s; exp_t e;
    push(st(T_R, 3'd0, 7'd0, 1'b0, 3'b000), c_fetch(1'b0), 1'b0, "add.wait0");
    push(st(T_R, 3'd0, 7'd0, 1'b0, 3'b000), c_fetch(1'b0), 1'b0, "add.wait1");
    push_alu(T_R, 3'b000, 7'h00, 4'd0, "add");
    push_alu(T_R, 3'b000, 7'h20, 4'd1, "sub");
    push_alu(T_I, 3'b101, 7'h20, 4'd9, "srai");
    push_alu(T_I, 3'b000, 7'h20, 4'd0, "addi");
    push_alu(T_R, 3'b011, 7'h00, 4'd6, "sltu");
    push_alu(T_R, 3'b101, 7'h00, 4'd8, "srl");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s);
      @(negedge clk);
      checks++;
      if (obs !== e.c) begin errors++; $display("FAIL %s: controls got %h want %h", e.nm, obs, e.c); end
      checks++;
      if (instret !== e.cnt || instret4 !== e.cnt[3:0]) begin
        errors++; $display("FAIL %s: instret got %0d/%0d want %0d", e.nm, instret, instret4, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_load_store();
    stim_t s; exp_t e;
    push(st(T_LOAD, 3'b010, 7'd0, 1'b1, 3'b000), c_fetch(1'b1), 1'b0, "lw.fetch");
    push(st(T_LOAD, 3'b010, 7'd0, 1'b1, 3'b000), c_dec(3'b000), 1'b0, "lw.decode");
    push(st(T_LOAD, 3'b010, 7'd0, 1'b1, 3'b000), c_madr(3'b000), 1'b0, "lw.adr");
    for (int i = 0; i < 3; i++)
      push(st(T_LOAD, 3'b010, 7'd0, 1'b0, 3'b000), c_mem(1'b0), 1'b0, "lw.read_wait");
    push(st(T_LOAD, 3'b010, 7'd0, 1'b1, 3'b000), c_mem(1'b0), 1'b0, "lw.read_done");
    push(st(T_LOAD, 3'b010, 7'd0, 1'b1, 3'b000), c_wb(2'b01), 1'b1, "lw.wb");
    push(st(T_STORE, 3'b010, 7'd0, 1'b1, 3'b000), c_fetch(1'b1), 1'b0, "sw.fetch");
    push(st(T_STORE, 3'b010, 7'd0, 1'b1, 3'b000), c_dec(3'b001), 1'b0, "sw.decode");
    push(st(T_STORE, 3'b010, 7'd0, 1'b1, 3'b000), c_madr(3'b001), 1'b0, "sw.adr");
    for (int i = 0; i < 2; i++)
      push(st(T_STORE, 3'b010, 7'd0, 1'b0, 3'b000), c_mem(1'b1), 1'b0, "sw.write_wait");
    push(st(T_STORE, 3'b010, 7'd0, 1'b1, 3'b000), c_mem(1'b1), 1'b1, "sw.write_done");
    push(st(T_R, 3'b000, 7'd0, 1'b0, 3'b000), c_fetch(1'b0), 1'b0, "sw.next_fetch");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s);
      @(negedge clk);
      checks++;
      if (obs !== e.c) begin errors++; $display("FAIL %s: controls got %h want %h", e.nm, obs, e.c); end
      checks++;
      if (instret !== e.cnt || instret4 !== e.cnt[3:0]) begin
        errors++; $display("FAIL %s: instret got %0d/%0d want %0d", e.nm, instret, instret4, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    stim_t s; exp_t e;
    push_br(3'b001, 3'b000, 1'b1, "bne_taken");
    push_br(3'b111, 3'b001, 1'b0, "bgeu_not");
    push_br(3'b100, 3'b010, 1'b1, "blt_taken");
    push_br(3'b000, 3'b000, 1'b0, "beq_not");
    push_br(3'b101, 3'b000, 1'b1, "bge_taken");
    push(st(T_JAL, 3'd0, 7'd0, 1'b1, 3'b000), c_fetch(1'b1), 1'b0, "jal.fetch");
    push(st(T_JAL, 3'd0, 7'd0, 1'b1, 3'b000), c_dec(3'b011), 1'b0, "jal.decode");
    push(st(T_JAL, 3'd0, 7'd0, 1'b1, 3'b000), c_jal(), 1'b0, "jal.jump");
    push(st(T_JAL, 3'd0, 7'd0, 1'b1, 3'b000), c_wb(2'b00), 1'b1, "jal.wb");
    push(st(T_LUI, 3'd0, 7'd0, 1'b1, 3'b000), c_fetch(1'b1), 1'b0, "lui.fetch");
    push(st(T_LUI, 3'd0, 7'd0, 1'b1, 3'b000), c_dec(3'b100), 1'b0, "lui.decode");
    push(st(T_LUI, 3'd0, 7'd0, 1'b1, 3'b000), c_lui(), 1'b0, "lui.exec");
    push(st(T_LUI, 3'd0, 7'd0, 1'b1, 3'b000), c_wb(2'b00), 1'b1, "lui.wb");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s);
      @(negedge clk);
      checks++;
      if (obs !== e.c) begin errors++; $display("FAIL %s: controls got %h want %h", e.nm, obs, e.c); end
      checks++;
      if (instret !== e.cnt || instret4 !== e.cnt[3:0]) begin
        errors++; $display("FAIL %s: instret got %0d/%0d want %0d", e.nm, instret, instret4, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_trap();
    stim_t s; exp_t e;
    push(st(T_SYS, 3'd0, 7'd0, 1'b1, 3'b000), c_fetch(1'b1), 1'b0, "ecall.fetch");
    push(st(T_SYS, 3'd0, 7'd0, 1'b1, 3'b000), c_dec(3'b000), 1'b0, "ecall.decode");
    for (int i = 0; i < 12; i++)
      push(st(T_SYS, 3'd0, 7'd0, 1'(i), 3'b000), c_trap(), 1'b0, "ecall.trap");
    push_rst("ecall.reset");
    push(st(T_BR, 3'b010, 7'd0, 1'b0, 3'b000), c_fetch(1'b0), 1'b0, "post_reset.fetch");
    push(st(T_BR, 3'b010, 7'd0, 1'b1, 3'b000), c_fetch(1'b1), 1'b0, "badbr.fetch");
    push(st(T_BR, 3'b010, 7'd0, 1'b1, 3'b000), c_dec(3'b010), 1'b0, "badbr.decode");
    push(st(T_BR, 3'b010, 7'd0, 1'b1, 3'b100), c_br(1'b0), 1'b0, "badbr.branch");
    push(st(T_BR, 3'b010, 7'd0, 1'b1, 3'b000), c_trap(), 1'b0, "badbr.trap0");
    push(st(T_BR, 3'b010, 7'd0, 1'b0, 3'b000), c_trap(), 1'b0, "badbr.trap1");
    push_rst("badbr.reset");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s);
      @(negedge clk);
      checks++;
      if (obs !== e.c) begin errors++; $display("FAIL %s: controls got %h want %h", e.nm, obs, e.c); end
      checks++;
      if (instret !== e.cnt || instret4 !== e.cnt[3:0]) begin
        errors++; $display("FAIL %s: instret got %0d/%0d want %0d", e.nm, instret, instret4, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap();
    stim_t s; exp_t e;
    for (int i = 0; i < 16; i++) push_alu(T_R, 3'b110, 7'h00, 4'd3, "or_wrap");
    push(st(T_R, 3'd0, 7'd0, 1'b0, 3'b000), c_fetch(1'b0), 1'b0, "wrap.after");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s);
      @(negedge clk);
      checks++;
      if (obs !== e.c) begin errors++; $display("FAIL %s: controls got %h want %h", e.nm, obs, e.c); end
      checks++;
      if (instret !== e.cnt || instret4 !== e.cnt[3:0]) begin
        errors++; $display("FAIL %s: instret got %0d/%0d want %0d", e.nm, instret, instret4, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_write();
    stim_t s; exp_t e;
    push(st(T_STORE, 3'b010, 7'd0, 1'b1, 3'b000), c_fetch(1'b1), 1'b0, "sw2.fetch");
    push(st(T_STORE, 3'b010, 7'd0, 1'b1, 3'b000), c_dec(3'b001), 1'b0, "sw2.decode");
    push(st(T_STORE, 3'b010, 7'd0, 1'b1, 3'b000), c_madr(3'b001), 1'b0, "sw2.adr");
    push(st(T_STORE, 3'b010, 7'd0, 1'b0, 3'b000), c_mem(1'b1), 1'b0, "sw2.write_wait");
    push_rst("sw2.reset_in_wait");
    push(st(T_STORE, 3'b010, 7'd0, 1'b0, 3'b000), c_fetch(1'b0), 1'b0, "sw2.refetch");
    push(st(T_STORE, 3'b010, 7'd0, 1'b0, 3'b000), c_fetch(1'b0), 1'b0, "sw2.refetch_hold");
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front(); e = exp_q.pop_front();
      drive(s);
      @(negedge clk);
      checks++;
      if (obs !== e.c) begin errors++; $display("FAIL %s: controls got %h want %h", e.nm, obs, e.c); end
      checks++;
      if (instret !== e.cnt || instret4 !== e.cnt[3:0]) begin
        errors++; $display("FAIL %s: instret got %0d/%0d want %0d", e.nm, instret, instret4, e.cnt);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_load_store();
    test_branch_jump();
    test_trap();
    test_wrap();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
